// File: rtl/imem_loader.sv
// imem_loader: turns a length-prefixed byte stream into 32-bit instruction memory writes and holds the core in reset until the load succeeds.
// Optional trailing XOR checksum byte, enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  localparam logic [2:0] S_HDR0  = 3'd0;
  localparam logic [2:0] S_HDR1  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK         = 3'd5;
  localparam logic [2:0] S_PAYLOAD_END = S_CHK;
`else
  localparam logic [2:0] S_PAYLOAD_END = S_DONE;
`endif

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic              r_rx_ready;
  logic [7:0]        r_n_lo;
  logic [15:0]       r_n;
  logic [1:0]        r_byte_cnt;
  logic [15:0]       r_idx;
  logic [23:0]       r_asm;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_cpu_reset;
  logic              r_done;
  logic              r_error;
  logic [15:0]       r_word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic        w_accept;
  logic [15:0] w_hdr_n;
  logic        w_word_done;
  logic        w_last_word;

  // rx_ready is a pure function of state; it is registered from the next state so it tracks r_state exactly.
  function automatic logic f_ready(input logic [2:0] st);
    case (st)
      S_HDR0, S_HDR1, S_LOAD: f_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:                  f_ready = 1'b1;
`endif
      default:                f_ready = 1'b0;
    endcase
  endfunction

  assign w_accept    = rx_valid && r_rx_ready;
  assign w_hdr_n     = {rx_data, r_n_lo};
  assign w_word_done = w_accept && (r_state == S_LOAD) && (r_byte_cnt == 2'd3);
  assign w_last_word = (r_idx == (r_n - 16'd1));

  // Next-state decode for the load sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_HDR0: begin
        if (w_accept) w_next_state = S_HDR1;
        else          w_next_state = S_HDR0;
      end
      S_HDR1: begin
        if (!w_accept)                       w_next_state = S_HDR1;
        else if (w_hdr_n == 16'd0)           w_next_state = S_PAYLOAD_END;
        else if (w_hdr_n > 16'(DEPTH_WORDS)) w_next_state = S_ERROR;
        else                                 w_next_state = S_LOAD;
      end
      S_LOAD: begin
        if (w_word_done && w_last_word) w_next_state = S_PAYLOAD_END;
        else                            w_next_state = S_LOAD;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (!w_accept)              w_next_state = S_CHK;
        else if (rx_data == r_csum) w_next_state = S_DONE;
        else                        w_next_state = S_ERROR;
      end
`endif
      S_DONE: begin
        if (start) w_next_state = S_HDR0;
        else       w_next_state = S_DONE;
      end
      S_ERROR: begin
        if (start) w_next_state = S_HDR0;
        else       w_next_state = S_ERROR;
      end
      default: w_next_state = S_ERROR;
    endcase
  end

  // Sequencer state and status flags; cpu_reset drops only after a full cycle spent in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_HDR0;
      r_rx_ready  <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cpu_reset <= 1'b1;
    end else begin
      r_state     <= w_next_state;
      r_rx_ready  <= f_ready(w_next_state);
      r_done      <= (w_next_state == S_DONE);
      r_error     <= (w_next_state == S_ERROR);
      r_cpu_reset <= !((r_state == S_DONE) && (w_next_state == S_DONE));
    end
  end

  // Header capture, word assembly and the instruction memory write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n_lo       <= 8'h00;
      r_n          <= 16'h0000;
      r_byte_cnt   <= 2'd0;
      r_idx        <= 16'h0000;
      r_asm        <= 24'h000000;
      r_we         <= 1'b0;
      r_addr       <= {ADDR_W{1'b0}};
      r_wdata      <= 32'h0000_0000;
      r_word_count <= 16'h0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum       <= 8'h00;
`endif
    end else begin
      r_we <= w_word_done;
      if (w_accept && (r_state == S_HDR0)) begin
        r_n_lo <= rx_data;
      end
      if (w_accept && (r_state == S_HDR1)) begin
        r_n          <= w_hdr_n;
        r_byte_cnt   <= 2'd0;
        r_idx        <= 16'h0000;
        r_word_count <= 16'h0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_csum       <= 8'h00;
`endif
      end
      if (w_accept && (r_state == S_LOAD)) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_csum     <= r_csum ^ rx_data;
`endif
        case (r_byte_cnt)
          2'd0:    r_asm[7:0]   <= rx_data;
          2'd1:    r_asm[15:8]  <= rx_data;
          2'd2:    r_asm[23:16] <= rx_data;
          default: r_asm        <= r_asm;
        endcase
      end
      // The fourth byte goes straight into the write data; it never lands in r_asm.
      if (w_word_done) begin
        r_addr       <= {r_idx[ADDR_W-3:0], 2'b00};
        r_wdata      <= {rx_data, r_asm};
        r_idx        <= r_idx + 16'd1;
        r_word_count <= r_word_count + 16'd1;
      end
      if (start && ((r_state == S_DONE) || (r_state == S_ERROR))) begin
        r_word_count <= 16'h0000;
      end
    end
  end

  assign rx_ready   = r_rx_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: streams are built in a queue, the expected writes are derived from the
// stream bytes, and an independent monitor checks every imem_we pulse against them.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;
  logic [15:0]   word_count;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  stim[$];

  imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_we", 32'(imem_we), 32'd0);
      end else begin
        check("write_addr", 32'(imem_addr), exp_addr_q.pop_front());
        check("write_data", imem_wdata, exp_data_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      check("ready_in_gap", 32'(rx_ready), 32'd1);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    check("ready_at_send", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // XOR of every byte after the two header bytes, appended as the checksum byte.
  task automatic append_csum(input bit bad);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < stim.size(); i++) x ^= stim[i];
    if (bad) x ^= 8'($urandom_range(255, 1));
    stim.push_back(x);
  endtask

  task automatic build_stream(input int n, input bit bad);
    logic [15:0] n16;
    n16 = 16'(n);
    stim.delete();
    stim.push_back(n16[7:0]);
    stim.push_back(n16[15:8]);
    if (n <= DEPTH) begin
      for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
    end
    append_csum(bad);
  endtask

  task automatic restart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_done", 32'(done), 32'd0);
    check("restart_error", 32'(error), 32'd0);
    check("restart_word_count", 32'(word_count), 32'd0);
    check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    check("restart_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  // Reference model: expected writes and outcome come straight from the stream contents.
  task automatic run_stream(input int min_gap, input int max_gap);
    int n;
    int nbytes;
    int k;
    bit exp_err;
    logic [7:0] x;
    n = int'({stim[1], stim[0]});
    x = 8'h00;
    exp_err = 1'b0;
    if (n > DEPTH) begin
      exp_err = 1'b1;
      nbytes  = 2;
    end else begin
      for (int w = 0; w < n; w++) begin
        exp_addr_q.push_back(32'(4 * w));
        exp_data_q.push_back({stim[2+4*w+3], stim[2+4*w+2], stim[2+4*w+1], stim[2+4*w]});
        for (int j = 0; j < 4; j++) x ^= stim[2+4*w+j];
      end
      nbytes = 2 + 4 * n;
`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_err = (stim[nbytes] != x);
      nbytes  = nbytes + 1;
`endif
    end
    for (int i = 0; i < nbytes; i++) send_byte(stim[i], int'($urandom_range(max_gap, min_gap)));
    k = 0;
    while (!(done || error) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("end_reached", 32'(k < 100), 32'd1);
    @(negedge clk);
    check("end_done", 32'(done), 32'(!exp_err));
    check("end_error", 32'(error), 32'(exp_err));
    check("end_word_count", 32'(word_count), (n > DEPTH) ? 32'd0 : 32'(n));
    check("end_cpu_reset_entry", 32'(cpu_reset), 32'd1);
    check("end_rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    check("end_cpu_reset_after", 32'(cpu_reset), exp_err ? 32'd1 : 32'd0);
    check("pending_writes", 32'(exp_addr_q.size()), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    restart();
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_rx_ready", 32'(rx_ready), 32'd1);
    check("post_rst_cpu_reset", 32'(cpu_reset), 32'd1);

    // Two-word program, back-to-back then with three idle cycles before every byte.
    stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    append_csum(1'b0);
    run_stream(0, 0);
    stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    append_csum(1'b0);
    run_stream(3, 3);

    // Oversized header, empty program, and a full-depth program.
    build_stream(65, 1'b0);
    run_stream(0, 2);
    build_stream(0, 1'b0);
    run_stream(0, 2);
    build_stream(DEPTH, 1'b0);
    run_stream(0, 1);

    // Reset after six payload bytes: only word 0 may be written.
    build_stream(2, 1'b0);
    exp_addr_q.push_back(32'd0);
    exp_data_q.push_back({stim[5], stim[4], stim[3], stim[2]});
    for (int i = 0; i < 8; i++) send_byte(stim[i], int'($urandom_range(1, 0)));
    repeat (2) @(negedge clk);
    check("midrst_pending", 32'(exp_addr_q.size()), 32'd0);
    check("midrst_wc_before", 32'(word_count), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_rx_ready", 32'(rx_ready), 32'd0);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_word_count", 32'(word_count), 32'd0);
    check("midrst_addr", 32'(imem_addr), 32'd0);
    check("midrst_wdata", imem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rx_ready_after", 32'(rx_ready), 32'd1);
    build_stream(1, 1'b0);
    run_stream(0, 2);

    // Random programs, some with corrupted checksums when the checksum byte is in use.
    for (int t = 0; t < 8; t++) begin
      build_stream(int'($urandom_range(12, 1)), ($urandom_range(3, 0) == 0));
      run_stream(0, 3);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    stim = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
    run_stream(0, 0);
    stim = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h00};
    run_stream(0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
